mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and sequencer in front of `memory_rtl`. It lets two independent masters (port A, port B) share the single-ported memory as a dual-port RAM. It round-robins between pending requests, issues exactly one single-cycle `wr`/`rd` strobe per transaction, waits for the memory `response`, and returns read data plus status to the winning port. Out-of-range addresses are rejected locally and never reach the memory.

## Interface
- ADDR_WIDTH, 8, address width on both ports and memory side
- DATA_WIDTH, 32, data width
- MEM_SIZE, 16, number of valid locations; legal addr is 0..MEM_SIZE-1
- TIMEOUT, 16, response watchdog limit in cycles; used only when MEM_ARB_TIMEOUT_EN is defined
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-low
- a_req / b_req  in  1  request; held high with fields stable until ack
- a_wr / b_wr  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_WIDTH  request address
- a_wdata / b_wdata  in  DATA_WIDTH  write data
- a_ack / b_ack  out  1  one-cycle completion pulse
- a_err / b_err  out  1  valid with ack; 1 = range error or timeout
- a_rdata / b_rdata  out  DATA_WIDTH  read data; valid with ack; held until the next ack on that port
- mem_wr, mem_rd  out  1  memory strobes; single cycle, mutually exclusive
- mem_addr  out  ADDR_WIDTH  to memory
- mem_wdata  out  DATA_WIDTH  to memory
- mem_rdata  in  DATA_WIDTH  from memory
- mem_rsp  in  1  memory response/done, from `response`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req, pick the winner, latch its wr/addr/wdata, go to ISSUE. If the latched addr >= MEM_SIZE, go straight to RESP with err=1 and no strobe.
- ISSUE: assert mem_wr or mem_rd for exactly this cycle with latched addr/wdata, then go to WAIT.
- WAIT: hold mem_addr/mem_wdata. On mem_rsp=1, capture mem_rdata into the winner's rdata (reads only) and go to RESP.
- RESP: pulse the winner's ack. err=0 unless range error or timeout. Return to IDLE.
- Writes leave the port's rdata unchanged. Errored reads return rdata=0.
- Arbitration: 2-way round robin on a last_grant flag. Reset value is B, so A wins the first tie.
- Simultaneous requests: the winner alternates each tie. The loser keeps req high and is served in the next arbitration.
- A single requester is always granted, regardless of last_grant.
- Back-to-back: req still high in the cycle after ack is a new transaction.
- mem_rsp outside WAIT is ignored.
- Reset mid-transaction: all state is cleared at the next edge. The in-flight transaction is dropped with no ack.
- Reset values: all outputs 0, state IDLE, last_grant=B.

## Timing
- Request sampled at edge 0 in IDLE → strobe high between edge 1 and edge 2.
- mem_rsp sampled high at edge k (k ≥ 2) → ack high between edge k+1 and edge k+2.
- Minimum in-range latency is 3 cycles from request sample to ack, with the memory responding one cycle after the strobe.
- Range error: ack 2 cycles after the request sample.
- Throughput: at most one transaction in flight; no pipelining.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - WAIT counts cycles. After TIMEOUT cycles without mem_rsp, go to RESP with err=1 and rdata=0.
  - A late mem_rsp is ignored.
- Undefined:
  - WAIT holds indefinitely.
  - No counter logic; TIMEOUT is unused.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - port_id_e (PORT_A/PORT_B)
  - default TIMEOUT constant
- One sub-module, mem_arb_rr: 2-way round-robin picker. Inputs: req_a, req_b, last_grant. Output: grant. Purely combinational; last_grant is registered in the parent.
- The top-level module instantiates mem_arbiter between the requester interfaces and memory_rtl.

## Test plan
- Reset, then A writes 0xDEADBEEF to addr 3; A reads addr 3 → a_ack once, a_err=0, a_rdata=0xDEADBEEF; b_ack never asserted.
- A and B request together, continuously, for 4 transactions → grant order A,B,A,B; exactly one strobe per ack.
- B reads addr 16 with MEM_SIZE=16 → b_ack 2 cycles after request, b_err=1, b_rdata=0, mem_rd/mem_wr never asserted.
- Memory holds mem_rsp low for 20 cycles, MEM_ARB_TIMEOUT_EN defined → ack with err=1 after 16 WAIT cycles. Without the macro → ack 1 cycle after mem_rsp arrives, err=0.
- reset driven low during WAIT → next cycle all outputs 0, no ack for the dropped transaction; the next tie is granted to A.
- A issues back-to-back reads of addr 0..15 while B is idle → 16 acks; each ack cycle is followed by a new strobe 2 cycles later (IDLE→ISSUE).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter (mem_arbiter).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_id_e;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone requester always wins, ties go to the
// port that was not granted last.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic     req_a,
    input  logic     req_b,
    input  port_id_e last_grant,
    output port_id_e grant
);

    always_comb begin
        grant = PORT_A;
        if (req_a && req_b) begin
            grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            grant = PORT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-ported memory.
// Optional response watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 16,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_wr,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic                  a_err,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_wr,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic                  b_err,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_wr,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rsp
);

    state_e                state_q, state_d;
    port_id_e              last_q, last_d, owner_q, owner_d, grant;
    logic                  wr_q, wr_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rbuf_q, rbuf_d;
    logic                  mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d;
    logic                  a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic                  a_err_q, a_err_d, b_err_q, b_err_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
`endif

    mem_arb_rr u_rr (
        .req_a      (a_req),
        .req_b      (b_req),
        .last_grant (last_q),
        .grant      (grant)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rbuf_d    = rbuf_q;
        mem_wr_d  = 1'b0;
        mem_rd_d  = 1'b0;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_err_d   = 1'b0;
        b_err_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    owner_d = grant;
                    last_d  = grant;
                    wr_d    = (grant == PORT_A) ? a_wr    : b_wr;
                    addr_d  = (grant == PORT_A) ? a_addr  : b_addr;
                    wdata_d = (grant == PORT_A) ? a_wdata : b_wdata;
                    err_d   = 1'b0;
                    rbuf_d  = '0;
                    state_d = ISSUE;
                end
            end
            // Range check on the latched address keeps the error ack on the
            // same registered schedule as the strobe (ack two cycles after request).
            ISSUE: begin
                if (32'(addr_q) >= MEM_SIZE) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    mem_wr_d = wr_q;
                    mem_rd_d = !wr_q;
                    state_d  = WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            WAIT: begin
                if (mem_rsp) begin
                    rbuf_d  = mem_rdata;
                    state_d = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
                if (owner_q == PORT_A) begin
                    a_ack_d = 1'b1;
                    a_err_d = err_q;
                    if (!wr_q) a_rdata_d = err_q ? '0 : rbuf_q;
                end else begin
                    b_ack_d = 1'b1;
                    b_err_d = err_q;
                    if (!wr_q) b_rdata_d = err_q ? '0 : rbuf_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_q    <= PORT_B;
            owner_q   <= PORT_A;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rbuf_q    <= '0;
            mem_wr_q  <= 1'b0;
            mem_rd_q  <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rbuf_q    <= rbuf_d;
            mem_wr_q  <= mem_wr_d;
            mem_rd_q  <= mem_rd_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_err_q   <= a_err_d;
            b_err_q   <= b_err_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign mem_wr    = mem_wr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign a_ack     = a_ack_q;
    assign a_err     = a_err_q;
    assign a_rdata   = a_rdata_q;
    assign b_ack     = b_ack_q;
    assign b_err     = b_err_q;
    assign b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-port expected queues, a behavioural
// memory responder and a reference model of memory contents and port rdata.
module tb_mem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned MEM_SIZE = 16;
    localparam int unsigned TIMEOUT = 16;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk, reset;
    logic a_req, a_wr, b_req, b_wr;
    logic [AW-1:0] a_addr, b_addr, mem_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic a_ack, a_err, b_ack, b_err, mem_wr, mem_rd, mem_rsp;

    mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_SIZE   (MEM_SIZE),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_wr      (a_wr),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_err     (a_err),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_wr      (b_wr),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_err     (b_err),
        .b_rdata   (b_rdata),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rsp   (mem_rsp)
    );

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          qa[$], qb[$];
    int            grant_log[$];
    logic [DW-1:0] ref_mem[MEM_SIZE];
    logic [DW-1:0] mem_arr[MEM_SIZE];
    logic [DW-1:0] last_rd[2];
    int            ack_cnt[2];
    int            checks = 0, failures = 0;
    int            cyc = 0, last_ack_cyc = -1;
    int            strobes = 0, exp_strobes = 0;
    int            mem_delay = 0;
    bit            rand_delay = 1'b0, gap_mode = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural single-ported memory: responds mem_delay cycles after the strobe.
    initial begin : mem_model
        bit pending, prev_strobe, pwr;
        int cnt;
        logic [AW-1:0] paddr;
        pending = 0; prev_strobe = 0; pwr = 0; cnt = 0; paddr = '0;
        mem_rsp = 1'b0;
        mem_rdata = '0;
        foreach (mem_arr[i]) mem_arr[i] = '0;
        forever begin
            @(negedge clk);
            mem_rsp = 1'b0;
            if (!reset) begin
                pending = 0;
                prev_strobe = 0;
            end else begin
                if (mem_wr || mem_rd) begin
                    strobes++;
                    check("strobe_exclusive", longint'(mem_wr && mem_rd), 0);
                    check("strobe_single_cycle", longint'(prev_strobe), 0);
                    check("strobe_addr_in_range", longint'(mem_addr < MEM_SIZE), 1);
                    if (gap_mode && last_ack_cyc >= 0)
                        check("b2b_ack_to_strobe", cyc - last_ack_cyc, 2);
                    if (mem_wr && mem_addr < MEM_SIZE) mem_arr[mem_addr[3:0]] = mem_wdata;
                    pending = 1;
                    paddr = mem_addr;
                    pwr = mem_wr;
                    cnt = rand_delay ? int'($urandom_range(0, 3)) : mem_delay;
                end
                prev_strobe = mem_wr || mem_rd;
                if (pending) begin
                    if (cnt == 0) begin
                        mem_rsp = 1'b1;
                        mem_rdata = (pwr || paddr >= MEM_SIZE) ? $urandom : mem_arr[paddr[3:0]];
                        pending = 0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    task automatic score(input int p, input logic err, input logic [DW-1:0] rdata);
        exp_t e;
        if ((p == 0 && qa.size() == 0) || (p == 1 && qb.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack: port %0d acked with no pending request (cyc %0d)", p, cyc);
        end else begin
            e = (p == 0) ? qa.pop_front() : qb.pop_front();
            check(p == 0 ? "a_err" : "b_err", longint'(err), longint'(e.err));
            check(p == 0 ? "a_rdata" : "b_rdata", longint'(rdata), longint'(e.rdata));
        end
        grant_log.push_back(p);
        ack_cnt[p]++;
        last_ack_cyc = cyc;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (a_ack) score(0, a_err, a_rdata);
            if (b_ack) score(1, b_err, b_rdata);
        end
    end

    // Issue one transaction from a negedge; returns at the negedge inside the ack cycle.
    task automatic drive(input int p, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input bit hold, input bit chk_lat);
        exp_t e;
        bit oor, tmo, got;
        int w, exp_w;
        oor = addr >= MEM_SIZE;
        tmo = !oor && TO_EN && !rand_delay && mem_delay >= int'(TIMEOUT);
        e.err = oor || tmo;
        if (wr) begin
            e.rdata = last_rd[p];
            if (!oor) ref_mem[addr[3:0]] = wd;
        end else begin
            e.rdata = e.err ? '0 : ref_mem[addr[3:0]];
            last_rd[p] = e.rdata;
        end
        if (!oor) exp_strobes++;
        exp_w = oor ? 3 : (tmo ? int'(TIMEOUT) + 3 : 4 + mem_delay);
        if (p == 0) begin
            qa.push_back(e);
            a_req = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wd;
        end else begin
            qb.push_back(e);
            b_req = 1'b1; b_wr = wr; b_addr = addr; b_wdata = wd;
        end
        w = 0;
        got = 0;
        while (!got && w < 300) begin
            @(negedge clk);
            w++;
            got = (p == 0) ? a_ack : b_ack;
        end
        if (!got) check(p == 0 ? "a_ack_timeout" : "b_ack_timeout", 0, 1);
        else if (chk_lat) check(p == 0 ? "a_latency" : "b_latency", w, exp_w);
        if (!hold) begin
            if (p == 0) a_req = 1'b0;
            else b_req = 1'b0;
        end
    endtask

    task automatic rand_port(input int p, input int n);
        int gap, next_gap;
        bit wr;
        logic [AW-1:0] addr;
        gap = int'($urandom_range(0, 3));
        for (int i = 0; i < n; i++) begin
            repeat (gap) @(negedge clk);
            next_gap = (i == n - 1) ? 1 : int'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) addr = AW'($urandom_range(16, 255));
            else addr = AW'(p * 8 + int'($urandom_range(0, 7)));
            drive(p, wr, addr, $urandom, next_gap == 0, 1'b0);
            gap = next_gap;
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, longint'({a_ack, a_err, b_ack, b_err, mem_wr, mem_rd}), 0);
        check({name, "_data"}, longint'(|{a_rdata, b_rdata, mem_addr, mem_wdata}), 0);
    endtask

    initial begin : stimulus
        int s0, a0;
        reset = 1'b0;
        a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        reset = 1'b1;
        @(negedge clk);

        // Single-port write then read back.
        drive(0, 1'b1, 8'd3, 32'hDEADBEEF, 1'b0, 1'b1);
        drive(0, 1'b0, 8'd3, '0, 1'b0, 1'b1);
        check("b_ack_count_idle", ack_cnt[1], 0);
        @(negedge clk);

        // Out-of-range read from B: no strobe, error ack two cycles after request.
        s0 = strobes;
        drive(1, 1'b0, 8'd16, '0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("range_err_no_strobe", strobes, s0);

        // Slow memory: response held off for 19 cycles.
        mem_delay = 19;
        drive(0, 1'b0, 8'd3, '0, 1'b0, 1'b1);
        mem_delay = 0;
        repeat (25) @(negedge clk);

        // Reset while the memory is still being waited on.
        a_req = 1'b1; a_wr = 1'b0; a_addr = 8'd2;
        mem_delay = 40;
        exp_strobes++;
        a0 = ack_cnt[0];
        repeat (6) @(negedge clk);
        reset = 1'b0;
        a_req = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_reset_outputs");
        last_rd[0] = '0; last_rd[1] = '0;
        @(negedge clk);
        reset = 1'b1;
        mem_delay = 0;
        repeat (3) @(negedge clk);
        check("dropped_txn_no_ack", ack_cnt[0], a0);

        // Continuous tie between both ports.
        grant_log.delete();
        fork
            begin
                drive(0, 1'b1, 8'd5, 32'h1111_0005, 1'b1, 1'b0);
                drive(0, 1'b0, 8'd5, '0, 1'b0, 1'b0);
            end
            begin
                drive(1, 1'b1, 8'd9, 32'h2222_0009, 1'b1, 1'b0);
                drive(1, 1'b0, 8'd9, '0, 1'b0, 1'b0);
            end
        join
        check("tie_grant_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check("tie_grant_0", grant_log[0], 0);
            check("tie_grant_1", grant_log[1], 1);
            check("tie_grant_2", grant_log[2], 0);
            check("tie_grant_3", grant_log[3], 1);
        end
        @(negedge clk);

        // Randomized concurrent traffic with random memory latency.
        rand_delay = 1'b1;
        fork
            rand_port(0, 30);
            rand_port(1, 30);
        join
        rand_delay = 1'b0;
        repeat (8) @(negedge clk);

        // Back-to-back reads from A over the whole address range.
        gap_mode = 1'b1;
        last_ack_cyc = -1;
        a0 = ack_cnt[0];
        for (int i = 0; i < 16; i++)
            drive(0, 1'b0, AW'(i), '0, i < 15, 1'b1);
        gap_mode = 1'b0;
        check("b2b_ack_count", ack_cnt[0] - a0, 16);

        repeat (6) @(negedge clk);
        check("queues_drained", qa.size() + qb.size(), 0);
        check("strobe_count", strobes, exp_strobes);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
